seven_seg_scan: RTL and testbench

Parametrised, time-multiplexed seven-segment display driver: scans `NUM_DIGITS` common-anode digits from a packed hex value, with a built-in refresh prescaler, anti-ghosting blanking, per-digit enable, decimal points, leading-zero suppression and tear-free frame-synchronous value updates. It sits between the datapath's display value and the board's anode/cathode pins. It supersedes the free-running 8-digit scanner, which ran one digit per system clock and had no reset.

---
 rtl/seven_seg_scan_pkg.sv | 26 ++
 rtl/seven_seg_scan_seg7_font.sv | 11 +
 rtl/seven_seg_scan.sv | 117 +++++++++++
 tb/tb_seven_seg_scan.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_scan_pkg.sv
// Shared display definitions: active-low hex font, segment-off code and
// an anode-all-off mask builder.
package seven_seg_scan_pkg;

    localparam int MAX_DIGITS = 16;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low segments, bit 0 = a ... bit 6 = g; glyphs 0-9, A, b, C, d, E, F.
    localparam logic [6:0] SEG_FONT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [MAX_DIGITS-1:0] anode_all_off(input int width);
        logic [MAX_DIGITS-1:0] mask;
        mask = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < width) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/seven_seg_scan_seg7_font.sv
// Combinational hex nibble to active-low seven-segment lookup.
module seg7_font
    import seven_seg_scan_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_n_o
);

    assign seg_n_o = SEG_FONT[nibble_i];

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed common-anode scanner with refresh prescaler, slot blanking,
// leading-zero suppression and frame-synchronous value updates.
module seven_seg_scan
    import seven_seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int TICK_DIV     = 100000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    lz_suppress,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              cathode,
    output logic                    dp_n,
    output logic                    frame_start
);

    localparam int PRE_W = $clog2(TICK_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_BLANK = PRE_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    localparam logic [MAX_DIGITS-1:0] ANODE_OFF_WIDE = anode_all_off(NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF      = ANODE_OFF_WIDE[NUM_DIGITS-1:0];

    logic [PRE_W-1:0]            pre_q, pre_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0]     stage_q, stage_d;
    logic [NUM_DIGITS-1:0][3:0]  disp_q, disp_d;
    logic [NUM_DIGITS-1:0]       anode_q, anode_d;
    logic [6:0]                  cathode_q, cathode_d;
    logic                        dp_n_q, dp_n_d;
    logic                        frame_start_q, frame_start_d;

    logic                        pre_wrap;
    logic                        frame_end;
    logic [NUM_DIGITS:0]         zero_from;
    logic [NUM_DIGITS-1:0]       sel;
    logic                        dark;
    logic [6:0]                  font_seg;

    always_comb begin
        pre_wrap  = (pre_q == PRE_LAST);
        frame_end = pre_wrap && (idx_q == IDX_LAST);

        pre_d = pre_wrap ? '0 : pre_q + 1'b1;
        idx_d = idx_q;
        if (pre_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        // A load on the boundary cycle bypasses staging straight into display.
        stage_d = load ? value : stage_q;
        disp_d  = frame_end ? stage_d : disp_q;
    end

    // zero_from[i]: every display nibble from the top digit down to i is zero.
    always_comb begin
        zero_from             = '0;
        zero_from[NUM_DIGITS] = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_from[i] = zero_from[i+1] && (disp_q[i] == 4'h0);
        end
    end

    seg7_font u_font (
        .nibble_i (disp_q[idx_q]),
        .seg_n_o  (font_seg)
    );

    always_comb begin
        sel  = NUM_DIGITS'(1) << idx_q;
        dark = (pre_q < PRE_BLANK)
            || !digit_en[idx_q]
            || (lz_suppress && (idx_q != '0) && zero_from[idx_q]);

        anode_d       = dark ? ANODE_OFF : ~sel;
        cathode_d     = dark ? SEG_OFF : font_seg;
        dp_n_d        = dark || !dp[idx_q];
        frame_start_d = (pre_q == '0) && (idx_q == '0);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pre_q         <= '0;
            idx_q         <= '0;
            stage_q       <= '0;
            disp_q        <= '0;
            anode_q       <= ANODE_OFF;
            cathode_q     <= SEG_OFF;
            dp_n_q        <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            pre_q         <= pre_d;
            idx_q         <= idx_d;
            stage_q       <= stage_d;
            disp_q        <= disp_d;
            anode_q       <= anode_d;
            cathode_q     <= cathode_d;
            dp_n_q        <= dp_n_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign anode       = anode_q;
    assign cathode     = cathode_q;
    assign dp_n        = dp_n_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan (4 digits, 8-cycle slots, 2 blank cycles)
// with a cycle-level scoreboard plus per-frame glyph snapshots.
module tb_seven_seg_scan;

    localparam int N = 4;
    localparam int T = 8;
    localparam int B = 2;

    logic         clk;
    logic         reset_n;
    logic [15:0]  value;
    logic         load;
    logic [3:0]   digit_en;
    logic [3:0]   dp;
    logic         lz_suppress;
    logic [3:0]   anode;
    logic [6:0]   cathode;
    logic         dp_n;
    logic         frame_start;

    seven_seg_scan #(
        .NUM_DIGITS   (N),
        .TICK_DIV     (T),
        .BLANK_CYCLES (B)
    ) dut (
        .clock       (clk),
        .reset_n     (reset_n),
        .value       (value),
        .load        (load),
        .digit_en    (digit_en),
        .dp          (dp),
        .lz_suppress (lz_suppress),
        .anode       (anode),
        .cathode     (cathode),
        .dp_n        (dp_n),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] cat;
        logic       dpn;
        logic       fs;
    } exp_t;

    exp_t  sb[$];
    int    n_total = 0;
    int    n_pass  = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    int    last_fs = -1;
    int    dark_run = 0;
    logic  ghost_en = 1'b0;
    logic  obs_fs   = 1'b0;

    int          m_pre, m_idx;
    logic [15:0] m_stage, m_disp;

    logic [6:0] seen_cat [N];
    logic       seen_dpn [N];

    // Font written in conventional active-high gfedcba form, inverted for the pins.
    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] hi;
        case (n)
            4'h0: hi = 7'h3F; 4'h1: hi = 7'h06; 4'h2: hi = 7'h5B; 4'h3: hi = 7'h4F;
            4'h4: hi = 7'h66; 4'h5: hi = 7'h6D; 4'h6: hi = 7'h7D; 4'h7: hi = 7'h07;
            4'h8: hi = 7'h7F; 4'h9: hi = 7'h6F; 4'hA: hi = 7'h77; 4'hB: hi = 7'h7C;
            4'hC: hi = 7'h39; 4'hD: hi = 7'h5E; 4'hE: hi = 7'h79; default: hi = 7'h71;
        endcase
        return ~hi;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        exp_t        e;
        int          hd;
        logic        lit;
        logic [3:0]  nib;
        int          pos;
        if (!reset_n) begin
            e.an = 4'hF; e.cat = 7'h7F; e.dpn = 1'b1; e.fs = 1'b0;
            m_pre = 0; m_idx = 0; m_stage = '0; m_disp = '0;
            last_fs = -1;
        end else begin
            hd = -1;
            for (int i = 0; i < N; i++) if (m_disp[4*i +: 4] != 4'h0) hd = i;
            nib = m_disp[4*m_idx +: 4];
            lit = (m_pre >= B) && digit_en[m_idx]
               && !(lz_suppress && m_idx != 0 && m_idx > hd);
            e.fs = (m_pre == 0) && (m_idx == 0);
            if (lit) begin
                e.an  = 4'hF & ~(4'b0001 << m_idx);
                e.cat = glyph(nib);
                e.dpn = ~dp[m_idx];
            end else begin
                e.an = 4'hF; e.cat = 7'h7F; e.dpn = 1'b1;
            end
            if (m_pre == T - 1) begin
                m_pre = 0;
                if (m_idx == N - 1) begin
                    m_idx  = 0;
                    m_disp = load ? value : m_stage;
                end else begin
                    m_idx++;
                end
            end else begin
                m_pre++;
            end
            if (load) m_stage = value;
        end
        sb.push_back(e);

        @(posedge clk);
        @(negedge clk);
        cyc++;

        e = sb.pop_front();
        chk("anode",       32'(anode),       32'(e.an));
        chk("cathode",     32'(cathode),     32'(e.cat));
        chk("dp_n",        32'(dp_n),        32'(e.dpn));
        chk("frame_start", 32'(frame_start), 32'(e.fs));
        chk("ghost_onehot", 32'($countones(~anode) <= 1), 32'(1));

        obs_fs = frame_start;
        if (frame_start === 1'b1) begin
            if (last_fs >= 0) chk("fs_period", 32'(cyc - last_fs), 32'(N * T));
            last_fs = cyc;
        end

        if (anode === 4'hF) begin
            dark_run++;
        end else begin
            if (ghost_en && dark_run != 0) chk("blank_len", 32'(dark_run), 32'(B));
            dark_run = 0;
            pos = -1;
            for (int i = 0; i < N; i++) if (anode[i] === 1'b0) pos = i;
            if (pos >= 0) begin
                seen_cat[pos] = cathode;
                seen_dpn[pos] = dp_n;
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (obs_fs !== 1'b1 && n < 2 * N * T);
        chk("frame_seen", 32'(obs_fs), 32'(1));
    endtask

    task automatic clear_seen();
        for (int i = 0; i < N; i++) begin
            seen_cat[i] = 7'h7F;
            seen_dpn[i] = 1'b1;
        end
    endtask

    task automatic check_seen(input string tag, input logic [6:0] c3, input logic [6:0] c2,
                              input logic [6:0] c1, input logic [6:0] c0);
        chk({tag, "_d3"}, 32'(seen_cat[3]), 32'(c3));
        chk({tag, "_d2"}, 32'(seen_cat[2]), 32'(c2));
        chk({tag, "_d1"}, 32'(seen_cat[1]), 32'(c1));
        chk({tag, "_d0"}, 32'(seen_cat[0]), 32'(c0));
    endtask

    task automatic load_value(input logic [15:0] v);
        value = v;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        value = 16'hDEAD;
    endtask

    initial begin
        reset_n = 1'b0; value = '0; load = 1'b0;
        digit_en = 4'b1111; dp = 4'b0000; lz_suppress = 1'b0;
        m_pre = 0; m_idx = 0; m_stage = '0; m_disp = '0;
        clear_seen();

        // Reset, then first frame shows 0000 while 12AF is staged.
        ticks(3);
        chk("reset_anode",   32'(anode),       32'(4'hF));
        chk("reset_cathode", 32'(cathode),     32'(7'h7F));
        chk("reset_fs",      32'(frame_start), 32'(0));
        reset_n = 1'b1;
        wait_frame();
        clear_seen();
        ticks(2);
        load_value(16'h12AF);
        ticks(28);
        check_seen("frame0", glyph(4'h0), glyph(4'h0), glyph(4'h0), glyph(4'h0));

        // Three frames of 12AF with slot-blank length checked.
        ghost_en = 1'b1;
        for (int f = 0; f < 3; f++) begin
            wait_frame();
            clear_seen();
            ticks(N * T - 1);
            check_seen("frame12AF", glyph(4'h1), glyph(4'h2), glyph(4'hA), glyph(4'hF));
        end
        ghost_en = 1'b0;

        // Leading-zero suppression.
        lz_suppress = 1'b1;
        load_value(16'h0040);
        wait_frame();
        clear_seen();
        ticks(N * T - 1);
        check_seen("lz0040", 7'h7F, 7'h7F, glyph(4'h4), glyph(4'h0));

        load_value(16'h0000);
        wait_frame();
        clear_seen();
        ticks(N * T - 1);
        check_seen("lz0000", 7'h7F, 7'h7F, 7'h7F, glyph(4'h0));

        // Per-digit enable and decimal point.
        lz_suppress = 1'b0;
        digit_en = 4'b1011;
        dp = 4'b0010;
        load_value(16'h5678);
        wait_frame();
        clear_seen();
        ticks(N * T - 1);
        check_seen("en_dp", glyph(4'h5), 7'h7F, glyph(4'h7), glyph(4'h8));
        chk("dp_d0", 32'(seen_dpn[0]), 32'(1));
        chk("dp_d1", 32'(seen_dpn[1]), 32'(0));
        chk("dp_d3", 32'(seen_dpn[3]), 32'(1));

        // Tear-free: two mid-frame loads, last wins next frame.
        digit_en = 4'b1111;
        dp = 4'b0000;
        wait_frame();
        clear_seen();
        ticks(5);
        load_value(16'h1111);
        ticks(10);
        load_value(16'h2222);
        ticks(14);
        check_seen("tear_cur", glyph(4'h5), glyph(4'h6), glyph(4'h7), glyph(4'h8));
        wait_frame();
        clear_seen();
        ticks(N * T - 2);
        load_value(16'h3333);
        check_seen("tear_next", glyph(4'h2), glyph(4'h2), glyph(4'h2), glyph(4'h2));
        wait_frame();
        clear_seen();
        ticks(N * T - 1);
        check_seen("boundary_load", glyph(4'h3), glyph(4'h3), glyph(4'h3), glyph(4'h3));

        // Reset during slot 2 with a load pending.
        wait_frame();
        ticks(3);
        load_value(16'h9999);
        ticks(14);
        reset_n = 1'b0;
        tick();
        chk("midreset_dark", 32'(anode), 32'(4'hF));
        ticks(2);
        reset_n = 1'b1;
        tick();
        chk("fs_after_release", 32'(frame_start), 32'(1));
        clear_seen();
        ticks(N * T - 1);
        check_seen("after_reset", glyph(4'h0), glyph(4'h0), glyph(4'h0), glyph(4'h0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
